// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and region helpers shared by the
// sync generator and the overlay blocks that do region arithmetic.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;

   localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Sync windows, inclusive bounds (656..751 and 490..491 at defaults)
   localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FP;
   localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
   localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FP;
   localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

   // True when count lies in [start, start+len-1]
   function automatic logic in_window(input logic [CNT_W-1:0] c,
                                      input int start, input int len);
      return (int'(c) >= start) && (int'(c) < start + len);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping counter that advances on inc, plus a
// registered active-low sync derived from the next count so that sync
// and count always change on the same edge.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL      = DEF_H_TOTAL,
   parameter int SYNC_START = DEF_H_SYNC_START,
   parameter int SYNC_LEN   = DEF_H_SYNC
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             wrap,
   output logic             sync_n
);

   logic             at_end;
   logic [CNT_W-1:0] count_nxt;

   assign at_end = (count == CNT_W'(TOTAL - 1));
   // wrap marks the edge on which this axis returns to 0; it carries the
   // next axis up
   assign wrap   = inc && at_end;

   // Next count: hold, increment, or wrap to 0
   always_comb begin
      count_nxt = count;
      if (inc) count_nxt = at_end ? '0 : count + CNT_W'(1);
   end

   // Count and sync registers; sync looks at the next count for zero skew
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         sync_n <= 1'b1;
      end else begin
         count  <= count_nxt;
         sync_n <= !in_window(count_nxt, SYNC_START, SYNC_LEN);
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical axis
// counters, visible-area flag and end-of-frame pulse.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int H_DISPLAY = DEF_H_DISPLAY,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_DISPLAY = DEF_V_DISPLAY,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic             h_wrap;
   logic             v_wrap;

   // With CLK_DIV=1 div_cnt sits at 0 and p_tick is permanently high
   assign p_tick = (div_cnt == DIV_W'(CLK_DIV - 1));

   // Pixel-rate divider, restarts at phase 0 out of reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      div_cnt <= '0;
      else if (p_tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + DIV_W'(1);
   end

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .SYNC_START (H_DISPLAY + H_FP),
      .SYNC_LEN   (H_SYNC)
   ) u_h_axis (
      .clk    (clk),
      .reset  (reset),
      .inc    (p_tick),
      .count  (pixel_x),
      .wrap   (h_wrap),
      .sync_n (hsync)
   );

   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .SYNC_START (V_DISPLAY + V_FP),
      .SYNC_LEN   (V_SYNC)
   ) u_v_axis (
      .clk    (clk),
      .reset  (reset),
      .inc    (h_wrap),
      .count  (pixel_y),
      .wrap   (v_wrap),
      .sync_n (vsync)
   );

   assign video_on   = (pixel_x < 10'(H_DISPLAY)) && (pixel_y < 10'(V_DISPLAY));
   // Vertical wrap already implies p_tick at (H_TOTAL-1, V_TOTAL-1)
   assign frame_tick = v_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three builds (default 640x480 /2, small /3,
// small /1) against an elapsed-cycle model, plus literal spot checks.
module tb_vga_sync_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       pt;
      logic       vo;
      logic       hs;
      logic       vs;
      logic       ft;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   longint t = 0;   // rising edges since reset release

   always #5 clk = ~clk;

   logic       a_pt, a_vo, a_hs, a_vs, a_ft;
   logic [9:0] a_x, a_y;
   logic       b_pt, b_vo, b_hs, b_vs, b_ft;
   logic [9:0] b_x, b_y;
   logic       c_pt, c_vo, c_hs, c_vs, c_ft;
   logic [9:0] c_x, c_y;

   vga_sync_gen #(.CLK_DIV(2)) dut_a (
      .clk(clk), .reset(rst_n), .p_tick(a_pt), .pixel_x(a_x), .pixel_y(a_y),
      .video_on(a_vo), .hsync(a_hs), .vsync(a_vs), .frame_tick(a_ft));

   vga_sync_gen #(.CLK_DIV(3), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                  .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_b (
      .clk(clk), .reset(rst_n), .p_tick(b_pt), .pixel_x(b_x), .pixel_y(b_y),
      .video_on(b_vo), .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft));

   vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                  .V_DISPLAY(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_c (
      .clk(clk), .reset(rst_n), .p_tick(c_pt), .pixel_x(c_x), .pixel_y(c_y),
      .video_on(c_vo), .hsync(c_hs), .vsync(c_vs), .frame_tick(c_ft));

   // Elapsed time since release; an async reset drop zeroes it at once
   always @(posedge clk or negedge rst_n)
      if (!rst_n) t <= 0;
      else        t <= t + 1;

   // Outputs as a pure function of elapsed cycles and the timing parameters
   function automatic exp_t model(input int dv, input int hd, input int hf,
                                  input int hsy, input int hb, input int vd,
                                  input int vf, input int vsy, input int vb,
                                  input longint tt);
      exp_t   e;
      longint n, ht, vt, x, y;
      ht   = hd + hf + hsy + hb;
      vt   = vd + vf + vsy + vb;
      n    = tt / dv;
      x    = n % ht;
      y    = (n / ht) % vt;
      e.x  = 10'(x);
      e.y  = 10'(y);
      e.pt = ((tt % dv) == dv - 1);
      e.vo = (x < hd) && (y < vd);
      e.hs = !((x >= hd + hf) && (x < hd + hf + hsy));
      e.vs = !((y >= vd + vf) && (y < vd + vf + vsy));
      e.ft = e.pt && (x == ht - 1) && (y == vt - 1);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0d)", nm, act, req, t);
      end
   endtask

   task automatic chk_all(input string nm, input exp_t act, input exp_t e);
      chk({nm, ".x"},  32'(act.x),  32'(e.x));
      chk({nm, ".y"},  32'(act.y),  32'(e.y));
      chk({nm, ".pt"}, 32'(act.pt), 32'(e.pt));
      chk({nm, ".vo"}, 32'(act.vo), 32'(e.vo));
      chk({nm, ".hs"}, 32'(act.hs), 32'(e.hs));
      chk({nm, ".vs"}, 32'(act.vs), 32'(e.vs));
      chk({nm, ".ft"}, 32'(act.ft), 32'(e.ft));
   endtask

   // Every-cycle comparison of all three builds against the model
   always @(negedge clk) begin
      chk_all("a", {a_x, a_y, a_pt, a_vo, a_hs, a_vs, a_ft},
              model(2, 640, 16, 96, 48, 480, 10, 2, 33, t));
      chk_all("b", {b_x, b_y, b_pt, b_vo, b_hs, b_vs, b_ft},
              model(3, 8, 2, 3, 2, 4, 1, 2, 1, t));
      chk_all("c", {c_x, c_y, c_pt, c_vo, c_hs, c_vs, c_ft},
              model(1, 8, 2, 3, 2, 4, 1, 2, 1, t));
   end

   initial begin
      int   hs_lo, vs_lo, k, n;
      logic vo639, vo640, vo03, vo04, seen;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.x", 32'(a_x), 0);
      chk("rst.y", 32'(a_y), 0);
      chk("rst.hs", 32'(a_hs), 1);
      chk("rst.vs", 32'(a_vs), 1);
      chk("rst.vo", 32'(a_vo), 1);
      chk("rst.pt", 32'(a_pt), 0);
      chk("rst.ft", 32'(a_ft), 0);
      chk("rst.c_pt", 32'(c_pt), 1);

      // Release: first p_tick one edge later, x=1 after two
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("first_ptick", 32'(a_pt), 1);
      chk("first_x0", 32'(a_x), 0);
      @(negedge clk);
      chk("x_after_2", 32'(a_x), 1);
      chk("pt_after_2", 32'(a_pt), 0);

      // One full default line: hsync low 192 clks, y steps to 1
      hs_lo = 0; vo639 = 1'bx; vo640 = 1'bx;
      for (int i = 0; i < 1600; i++) begin
         @(negedge clk);
         if (!a_hs) hs_lo++;
         if (a_x == 10'd639 && a_y == 10'd0) vo639 = a_vo;
         if (a_x == 10'd640 && a_y == 10'd0) vo640 = a_vo;
      end
      chk("line_hs_low_clks", 32'(hs_lo), 192);
      chk("line_end_x", 32'(a_x), 1);
      chk("line_end_y", 32'(a_y), 1);
      chk("vo_639_0", 32'(vo639), 1);
      chk("vo_640_0", 32'(vo640), 0);

      // Async reset mid-hsync at x=700
      k = 0;
      while (a_x != 10'd700 && k < 2000) begin @(negedge clk); k++; end
      chk("reach_x700", 32'(k < 2000), 1);
      chk("x700_hs", 32'(a_hs), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async.x", 32'(a_x), 0);
      chk("async.y", 32'(a_y), 0);
      chk("async.hs", 32'(a_hs), 1);
      chk("async.vo", 32'(a_vo), 1);
      chk("async.pt", 32'(a_pt), 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("re_first_ptick", 32'(a_pt), 1);
      @(negedge clk);
      chk("re_x_after_2", 32'(a_x), 1);

      // Small /3 build: frame spacing, vsync width, frame_tick position
      k = 0;
      while (!b_ft && k < 1000) begin @(negedge clk); k++; end
      chk("b_first_ft", 32'(k < 1000), 1);
      chk("b_ft_x", 32'(b_x), 14);
      chk("b_ft_y", 32'(b_y), 7);
      k = 0; vs_lo = 0; vo03 = 1'bx; vo04 = 1'bx;
      do begin
         @(negedge clk); k++;
         if (!b_vs) vs_lo++;
         if (b_x == 10'd0 && b_y == 10'd3) vo03 = b_vo;
         if (b_x == 10'd0 && b_y == 10'd4) vo04 = b_vo;
      end while (!b_ft && k < 1000);
      chk("b_frame_clks", 32'(k), 360);
      chk("b_vs_low_clks", 32'(vs_lo), 90);
      chk("b_vo_0_3", 32'(vo03), 1);
      chk("b_vo_0_4", 32'(vo04), 0);

      // /1 build: a line is H_TOTAL clks
      k = 0;
      while (c_x != 10'd1 && k < 100) begin @(negedge clk); k++; end
      k = 0; seen = 1'b0;
      do begin @(negedge clk); k++; end while (c_x != 10'd1 && k < 100);
      chk("c_line_clks", 32'(k), 15);

      // Random run lengths with asynchronous resets at random phases
      repeat (25) begin
         n = int'($urandom_range(1, 900));
         repeat (n) @(negedge clk);
         #($urandom_range(1, 3)) rst_n = 1'b0;
         #1;
         chk("rnd_async.a_x", 32'(a_x), 0);
         chk("rnd_async.b_y", 32'(b_y), 0);
         chk("rnd_async.a_hs", 32'(a_hs), 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         #2 rst_n = 1'b1;
      end
      repeat (500) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator that drives the pixel-coordinate interface consumed by the text/font overlay and colour path. It divides the system clock into a pixel-rate enable and runs horizontal and vertical counters for 640x480 at 60 Hz. From those counters it produces `pixel_x`, `pixel_y`, `video_on`, and registered active-low `hsync`/`vsync`. It sits between the board clock and every pixel generator, which sample `pixel_x`, `pixel_y` and `video_on` directly.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel; must be ≥ 1.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal retrace.
- `H_BP`, 48: horizontal back porch.
- `V_DISPLAY`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical retrace.
- `V_BP`, 33: vertical back porch.

Ports:
- `clk`  in  1: system clock (50 MHz for the default timing). Single clock domain.
- `reset`  in  1: asynchronous, active-low. Asserted (0) clears all state immediately.
- `p_tick`  out  1: pixel enable, high for one `clk` cycle every `CLK_DIV` cycles.
- `pixel_x`  out  10: horizontal count, 0..H_TOTAL-1.
- `pixel_y`  out  10: vertical count, 0..V_TOTAL-1.
- `video_on`  out  1: high while `pixel_x` < H_DISPLAY and `pixel_y` < V_DISPLAY.
- `hsync`  out  1: active-low, registered.
- `vsync`  out  1: active-low, registered.
- `frame_tick`  out  1: one-`clk` pulse on the last pixel of a frame.

## Operation
- Derived values: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both must be ≤ 1024.
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `p_tick` = (`div_cnt` == CLK_DIV-1), combinational.
  - If CLK_DIV=1, `p_tick` is constantly 1 after reset.
- Horizontal counter: advances only on `p_tick`. At H_TOTAL-1 it wraps to 0.
- Vertical counter: advances only on `p_tick` when the horizontal counter wraps. At V_TOTAL-1 it wraps to 0.
- `hsync` next value is 0 when next-h is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] (656..751), otherwise 1.
- `vsync` next value is 0 when next-v is in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1] (490..491), otherwise 1.
- Sync values are computed from the next counts, so the sync registers stay aligned with `pixel_x`/`pixel_y`.
- `video_on` is combinational from the registered counts. It is not gated by `p_tick`.
- `frame_tick` = `p_tick` AND h == H_TOTAL-1 AND v == V_TOTAL-1.
- Counters, syncs and divider change only on rising `clk`. There is no enable or other input.

## Timing
- Reset values: `div_cnt`=0, `pixel_x`=0, `pixel_y`=0, `hsync`=1, `vsync`=1.
  - With CLK_DIV>1: `p_tick`=0 and `frame_tick`=0 during reset; `video_on`=1, since (0,0) is visible.
- First `p_tick` is asserted CLK_DIV-1 clock edges after reset deassertion. `pixel_x` becomes 1 on the following edge.
- Each count value holds for exactly CLK_DIV `clk` cycles. One frame is H_TOTAL·V_TOTAL·CLK_DIV = 840000 cycles at defaults.
- `hsync`/`vsync` change on the same edge as the count that enters or leaves the retrace window. There is zero cycles of skew between counts and syncs.
- Simultaneous wrap: at (799,524) with `p_tick`, both counters go to 0 on the same edge. `vsync` stays 1 and `frame_tick` is high in the preceding cycle.
- Reset asserted mid-frame: all outputs return to their reset values asynchronously. Counting restarts from (0,0) on the first edge after release, with the divider phase at 0.

## Structure
- Package `vga_timing_pkg` holds the default 640x480 constants, the derived H_TOTAL/V_TOTAL, and the sync window bounds. Overlay blocks import the same package for region arithmetic.
- Sub-module `vga_axis_counter` is instantiated twice (horizontal and vertical). Its parameters are TOTAL, SYNC_START and SYNC_LEN. Its inputs are `clk`, `reset` and `inc`. Its outputs are `count`, `wrap` and the registered `sync_n`.
- The top level contains the divider, the `video_on`/`frame_tick` logic and the two axis counters.

## Test plan
- Reset held low, then released: outputs are (0,0), `hsync`=`vsync`=1, `video_on`=1. The first `p_tick` occurs 1 clk after release (CLK_DIV=2), and `pixel_x`=1 after 2 clks.
- Run one full line: `pixel_x` goes 0→799→0 and `pixel_y` goes 0→1 on the wrap edge. `hsync` is 0 exactly for x=656..751, which is 192 clks.
- `video_on` boundaries: 1 at (639,0), 0 at (640,0), 0 at (0,480), 1 at (0,479).
- Run one full frame: `vsync` is 0 only for y=490..491, which is 3200 clks. `frame_tick` pulses are 840000 clks apart, and each pulse coincides with (799,524).
- Assert `reset` asynchronously at (700,300) mid-`hsync`: in the same cycle `hsync` goes to 1 and the counts go to 0, with no clock edge needed. After release, timing is identical to the first scenario.
- CLK_DIV=1 build: `p_tick` is constantly 1, `pixel_x` advances every clk, and a line is 800 clks.
